// File: rtl/slicel_cfg_pkg.sv
// slicel_cfg_pkg: shared state encoding and chain-geometry helpers for the configuration loader
package slicel_cfg_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SET} state_t;
  function automatic int num_words(input int word_w, input int chain_len);
    return (chain_len + word_w - 1) / word_w;
  endfunction
  function automatic int last_bits(input int word_w, input int chain_len);
    return chain_len - (num_words(word_w, chain_len) - 1) * word_w;
  endfunction
endpackage

// File: rtl/cfg_word_serializer.sv
// cfg_word_serializer: two-slot word buffer that presents configuration bits MSB-first
module cfg_word_serializer #(
  parameter int WORD_W = 32,
  parameter int LAST_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              is_last,
  input  logic              shift,
  output logic              bit_data,
  output logic              bit_valid,
  output logic              empty
);
  localparam int CW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] shifter, hold;
  logic [CW-1:0] cnt;
  logic hold_last, hold_full, drain;
  assign drain = cnt == '0 || (shift && cnt == CW'(1));
  assign bit_data = shifter[WORD_W-1];
  assign bit_valid = cnt != '0;
  assign empty = !hold_full;
  // refill the shifter from holding (or straight from the input) on the edge it runs dry, so no bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shifter <= '0;
      hold <= '0;
      cnt <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
    end else if (clear) begin
      shifter <= '0;
      hold <= '0;
      cnt <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
    end else if (drain) begin
      shifter <= hold_full ? hold : load ? word : '0;
      cnt <= hold_full ? (hold_last ? CW'(LAST_BITS) : CW'(WORD_W)) :
             load ? (is_last ? CW'(LAST_BITS) : CW'(WORD_W)) : '0;
      hold_full <= 1'b0;
    end else begin
      if (shift) begin
        shifter <= shifter << 1;
        cnt <= cnt - 1'b1;
      end
      if (load) begin
        hold <= word;
        hold_last <= is_last;
        hold_full <= 1'b1;
      end
    end
endmodule

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: streams configuration words into a slice chain, then commits with a set strobe
module slicel_cfg_loader
  import slicel_cfg_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CHAIN_LEN = 132
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cfg_shift_en,
  output logic              cfg_shift_data,
  output logic              cfg_set,
  output logic              fabric_cen,
  output logic              busy,
  output logic              done
);
  localparam int NUM_WORDS = num_words(WORD_W, CHAIN_LEN);
  localparam int LAST_BITS = last_bits(WORD_W, CHAIN_LEN);
  localparam int BCW = $clog2(CHAIN_LEN + 1);
  localparam int WCW = $clog2(NUM_WORDS + 1);
  state_t state;
  logic [BCW-1:0] bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic clear, load, shift, bit_data, bit_valid, empty;
  assign in_ready = state == RUN && empty && word_cnt < WCW'(NUM_WORDS);
  assign load = in_ready && in_valid;
  assign shift = state == RUN && bit_valid;
  assign clear = (state == IDLE && start) || (state == RUN && abort);
  assign cfg_shift_en = shift;
  assign cfg_shift_data = shift && bit_data;
  cfg_word_serializer #(.WORD_W(WORD_W), .LAST_BITS(LAST_BITS)) u_ser (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .load(load),
    .word(in_data),
    .is_last(word_cnt == WCW'(NUM_WORDS - 1)),
    .shift(shift),
    .bit_data(bit_data),
    .bit_valid(bit_valid),
    .empty(empty)
  );
  // pass sequencing: saturating counters, commit strobe, completion pulse and slice clock gating
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      word_cnt <= '0;
      cfg_set <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      fabric_cen <= 1'b0;
    end else begin
      cfg_set <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        bit_cnt <= '0;
        word_cnt <= '0;
      end else begin
        if (shift && bit_cnt != BCW'(CHAIN_LEN)) bit_cnt <= bit_cnt + 1'b1;
        if (load && word_cnt != WCW'(NUM_WORDS)) word_cnt <= word_cnt + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
          fabric_cen <= 1'b0;
        end
        RUN: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else if (shift && bit_cnt == BCW'(CHAIN_LEN - 1)) begin
          state <= SET;
          cfg_set <= 1'b1;
        end
        SET: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          fabric_cen <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
